scalar_writeback_queue: RTL

- Write-side initiator for the scalar register file. It collects scalar results from the ALU and the memory/load unit and queues them in order.
- It drives the file's single write port (regWrEn/regToWrite/dataIn), committing at most one write per cycle.
- It snoops the file's two read selects and supplies forwarding data and a pending-register mask, so decode sees values that are still queued.

---
 rtl/scalar_writeback_queue.sv | 126 ++++++++++++
 1 files changed

// File: rtl/scalar_writeback_queue.sv
// rtl/scalar_writeback_queue.sv - in-order write-back queue for the scalar register file
// Merges ALU and load results, drains one per cycle, and forwards queued values to decode.
module scalar_writeback_queue #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              regWrEn,
  output logic [ADDR_W-1:0] regToWrite,
  output logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] rSel1,
  input  logic [ADDR_W-1:0] rSel2,
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data,
  output logic [REG_N-1:0]  pending,
  output logic              empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              w_pop;
  logic [CW:0]       w_free;
  logic              w_push_mem;
  logic              w_push_alu;
  logic [1:0]        w_n_push;
  logic [PW-1:0]     w_alu_slot;
  logic [PW-1:0]     w_idx;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW+1:0] s;
    s = {2'b00, p} + {{PW{1'b0}}, n};
    if (s >= (PW+2)'(DEPTH)) s = s - (PW+2)'(DEPTH);
    return s[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // The head drains every cycle it exists, so its slot counts as free for this cycle's pushes.
  assign w_pop      = (r_count != '0);
  assign w_free     = (CW+1)'(DEPTH) - {1'b0, r_count} + {{CW{1'b0}}, w_pop};
  assign mem_ready  = (w_free >= (CW+1)'(1));
  assign alu_ready  = (w_free >= (CW+1)'(2)) | ((w_free == (CW+1)'(1)) & ~mem_valid);
  assign w_push_mem = mem_valid & mem_ready;
  assign w_push_alu = alu_valid & alu_ready;
  assign w_n_push   = {1'b0, w_push_mem} + {1'b0, w_push_alu};
  assign w_alu_slot = wrap_add(r_tail, {1'b0, w_push_mem});

  assign regWrEn    = w_pop;
  assign regToWrite = w_pop ? r_rd[r_head]   : '0;
  assign dataIn     = w_pop ? r_data[r_head] : '0;
  assign empty      = ~w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push_mem) begin
        r_rd[r_tail]   <= mem_rd;
        r_data[r_tail] <= mem_data;
      end
      if (w_push_alu) begin
        r_rd[w_alu_slot]   <= alu_rd;
        r_data[w_alu_slot] <= alu_data;
      end
      r_tail  <= wrap_add(r_tail, w_n_push);
      r_head  <= wrap_add(r_head, {1'b0, w_pop});
      r_count <= r_count + CW'(w_n_push) - CW'(w_pop);
    end
  end

  // Walk oldest to youngest so the last match leaves the youngest data on the forward bus.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    pending   = '0;
    w_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(r_count)) begin
        w_idx = slot_of(r_head, k);
        pending[r_rd[w_idx]] = 1'b1;
        if (r_rd[w_idx] == rSel1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = r_data[w_idx];
        end
        if (r_rd[w_idx] == rSel2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = r_data[w_idx];
        end
      end
    end
  end

endmodule
